// File: rtl/clk_divider_multi.sv
// clk_divider_multi: multi-channel programmable clock divider / blink generator
//
// Each of NCH channels counts 0..P-1 on i_clk. It emits a square wave that is
// high while the count is below H, plus a one-cycle tick on the last count of
// each period. New P/H values are written through a shared config port into
// per-channel shadow registers. They become active at the next period
// boundary, or at once while the channel is disabled, so the output never
// glitches mid-period.
//
// Optional feature macro: CLKDIV_SYNC_EN adds the i_sync global restart port.
//
// Ports:
//   i_clk         sole clock, rising edge
//   i_rst_n       asynchronous active-low reset
//   i_en          per-channel run enable
//   i_cfg_we      config write strobe, one cycle per write
//   i_cfg_ch      target channel of the write (>= NCH is ignored)
//   i_cfg_period  new period P in clk cycles (values below 2 are stored as 2)
//   i_cfg_high    new high-time H in clk cycles
//   i_sync        global phase restart (CLKDIV_SYNC_EN only)
//   o_wave        per-channel divided square wave, registered
//   o_tick        per-channel end-of-period pulse, registered
//   o_pend        per-channel shadow config waiting to be applied
`timescale 1ns/1ps
module clk_divider_multi #(
   parameter int NCH        = 4,
   parameter int CNT_W      = 32,
   parameter int DEF_PERIOD = 100000000,
   parameter int DEF_HIGH   = 50000000
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [NCH-1:0]   i_en,
   input  logic             i_cfg_we,
   input  logic [3:0]       i_cfg_ch,
   input  logic [CNT_W-1:0] i_cfg_period,
   input  logic [CNT_W-1:0] i_cfg_high,
`ifdef CLKDIV_SYNC_EN
   input  logic             i_sync,
`endif
   output logic [NCH-1:0]   o_wave,
   output logic [NCH-1:0]   o_tick,
   output logic [NCH-1:0]   o_pend
);
   localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] TWO   = CNT_W'(2);
   localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEF_PERIOD);
   localparam logic [CNT_W-1:0] DEF_H = CNT_W'(DEF_HIGH);

   logic [CNT_W-1:0] r_cnt [NCH];
   logic [CNT_W-1:0] r_p   [NCH];
   logic [CNT_W-1:0] r_h   [NCH];
   logic [CNT_W-1:0] r_sp  [NCH];
   logic [CNT_W-1:0] r_sh  [NCH];
   logic [NCH-1:0]   r_wave, r_tick, r_pend;

   logic [CNT_W-1:0] w_sp  [NCH];
   logic [CNT_W-1:0] w_sh  [NCH];
   logic [CNT_W-1:0] w_cp;
   logic [NCH-1:0]   w_wr, w_wrap, w_apply;
   logic             w_sync;

`ifdef CLKDIV_SYNC_EN
   assign w_sync = i_sync;
`else
   assign w_sync = 1'b0;
`endif

   // Periods below 2 would never let the counter leave its wrap value.
   assign w_cp = (i_cfg_period < TWO) ? TWO : i_cfg_period;

   // w_sp/w_sh are the shadow values as they stand after this edge's write,
   // so a write landing on an apply edge is taken immediately.
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         w_wr[i]    = i_cfg_we && (i_cfg_ch == 4'(i));
         w_sp[i]    = w_wr[i] ? w_cp : r_sp[i];
         w_sh[i]    = w_wr[i] ? i_cfg_high : r_sh[i];
         w_wrap[i]  = i_en[i] && (r_cnt[i] == r_p[i] - ONE);
         w_apply[i] = !i_en[i] || w_wrap[i] || w_sync;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < NCH; i++) begin
            r_cnt[i] <= '0;
            r_p[i]   <= DEF_P;
            r_h[i]   <= DEF_H;
            r_sp[i]  <= DEF_P;
            r_sh[i]  <= DEF_H;
         end
         r_wave <= '0;
         r_tick <= '0;
         r_pend <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            r_sp[i] <= w_sp[i];
            r_sh[i] <= w_sh[i];
            if (w_apply[i]) begin
               r_p[i]    <= w_sp[i];
               r_h[i]    <= w_sh[i];
               r_pend[i] <= 1'b0;
            end else if (w_wr[i]) begin
               r_pend[i] <= 1'b1;
            end
            if (!i_en[i]) begin
               r_cnt[i]  <= '0;
               r_wave[i] <= 1'b0;
               r_tick[i] <= 1'b0;
            end else if (w_sync) begin
               // Restart phase; wave reflects the high-time now taking effect.
               r_cnt[i]  <= '0;
               r_wave[i] <= (w_sh[i] != '0);
               r_tick[i] <= 1'b0;
            end else begin
               r_cnt[i]  <= w_wrap[i] ? '0 : r_cnt[i] + ONE;
               r_wave[i] <= (r_cnt[i] < r_h[i]);
               r_tick[i] <= w_wrap[i];
            end
         end
      end
   end

   assign o_wave = r_wave;
   assign o_tick = r_tick;
   assign o_pend = r_pend;
endmodule

// File: tb/tb_clk_divider_multi.sv
// tb_clk_divider_multi: directed scoreboard bench for clk_divider_multi (NCH=2, CNT_W=8)
`timescale 1ns/1ps
module tb_clk_divider_multi;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] en;
   logic       cfg_we;
   logic [3:0] cfg_ch;
   logic [7:0] cfg_period, cfg_high;
   logic [1:0] wave, tick, pend;
`ifdef CLKDIV_SYNC_EN
   logic       sync;
`endif

   typedef struct {
      string      tag;
      logic [1:0] w;
      logic [1:0] t;
      logic [1:0] p;
   } exp_t;
   exp_t q[$];
   int n_chk = 0;
   int n_fail = 0;

   clk_divider_multi #(.NCH(2), .CNT_W(8), .DEF_PERIOD(10), .DEF_HIGH(5)) dut (
      .i_clk(clk),
      .i_rst_n(rst_n),
      .i_en(en),
      .i_cfg_we(cfg_we),
      .i_cfg_ch(cfg_ch),
      .i_cfg_period(cfg_period),
      .i_cfg_high(cfg_high),
`ifdef CLKDIV_SYNC_EN
      .i_sync(sync),
`endif
      .o_wave(wave),
      .o_tick(tick),
      .o_pend(pend)
   );

   always #5 clk = ~clk;

   // Expected wave/tick at the k-th enabled edge of a channel started at count 0.
   function automatic logic wv(input int k, input int p, input int h);
      return (k % p) < h;
   endfunction
   function automatic logic tk(input int k, input int p);
      return (k % p) == p - 1;
   endfunction

   task automatic chk();
      exp_t e;
      e = q.pop_front();
      n_chk++;
      assert (wave === e.w) else begin
         n_fail++;
         $error("FAIL %s wave: got %b expected %b", e.tag, wave, e.w);
      end
      n_chk++;
      assert (tick === e.t) else begin
         n_fail++;
         $error("FAIL %s tick: got %b expected %b", e.tag, tick, e.t);
      end
      n_chk++;
      assert (pend === e.p) else begin
         n_fail++;
         $error("FAIL %s pend: got %b expected %b", e.tag, pend, e.p);
      end
   endtask

   task automatic now(input string tag, input logic [1:0] w, input logic [1:0] t, input logic [1:0] p);
      q.push_back('{tag, w, t, p});
      chk();
   endtask

   task automatic cyc(input string tag, input logic [1:0] w, input logic [1:0] t, input logic [1:0] p);
      q.push_back('{tag, w, t, p});
      @(posedge clk);
      #1;
      chk();
      cfg_we = 1'b0;
`ifdef CLKDIV_SYNC_EN
      sync = 1'b0;
`endif
   endtask

   task automatic wr(input logic [3:0] ch, input logic [7:0] p, input logic [7:0] h);
      cfg_we = 1'b1;
      cfg_ch = ch;
      cfg_period = p;
      cfg_high = h;
   endtask

   initial begin
      rst_n = 1'b0;
      en = 2'b00;
      cfg_we = 1'b0;
      cfg_ch = '0;
      cfg_period = '0;
      cfg_high = '0;
`ifdef CLKDIV_SYNC_EN
      sync = 1'b0;
`endif
      #23;
      now("reset", 2'b00, 2'b00, 2'b00);
      @(negedge clk) rst_n = 1'b1;
      cyc("idle", 2'b00, 2'b00, 2'b00);
      cyc("idle", 2'b00, 2'b00, 2'b00);
      en = 2'b01;
      for (int k = 0; k < 20; k++) cyc("div10", {1'b0, wv(k, 10, 5)}, {1'b0, tk(k, 10)}, 2'b00);
      for (int k = 0; k < 3; k++) cyc("div10b", {1'b0, wv(k, 10, 5)}, {1'b0, tk(k, 10)}, 2'b00);
      wr(4'd0, 8'd4, 8'd1);
      cyc("wr_pend", 2'b01, 2'b00, 2'b01);
      for (int k = 4; k < 9; k++) cyc("pend_hold", {1'b0, wv(k, 10, 5)}, 2'b00, 2'b01);
      cyc("apply_wrap", 2'b00, 2'b01, 2'b00);
      for (int m = 0; m < 8; m++) cyc("p4h1", {1'b0, wv(m, 4, 1)}, {1'b0, tk(m, 4)}, 2'b00);
      en = 2'b00;
      wr(4'd0, 8'd0, 8'd1);
      cyc("dis_apply", 2'b00, 2'b00, 2'b00);
      en = 2'b01;
      for (int m = 0; m < 6; m++) cyc("clamp_p2", {1'b0, wv(m, 2, 1)}, {1'b0, tk(m, 2)}, 2'b00);
      en = 2'b00;
      wr(4'd0, 8'd4, 8'd0);
      cyc("dis_apply", 2'b00, 2'b00, 2'b00);
      en = 2'b01;
      for (int m = 0; m < 8; m++) cyc("h0", 2'b00, {1'b0, tk(m, 4)}, 2'b00);
      en = 2'b00;
      wr(4'd0, 8'd10, 8'd200);
      cyc("dis_apply", 2'b00, 2'b00, 2'b00);
      en = 2'b01;
      for (int m = 0; m < 30; m++) begin
         if (m == 2) wr(4'd3, 8'd4, 8'd1);
         if (m == 29) wr(4'd0, 8'd3, 8'd2);
         cyc("h_ge_p", 2'b01, {1'b0, tk(m, 10)}, 2'b00);
      end
      for (int m = 0; m < 6; m++) cyc("wrap_wr", {1'b0, wv(m, 3, 2)}, {1'b0, tk(m, 3)}, 2'b00);
      wr(4'd0, 8'd7, 8'd3);
      cyc("pre_rst", 2'b01, 2'b00, 2'b01);
      #3 rst_n = 1'b0;
      #1 now("rst_async", 2'b00, 2'b00, 2'b00);
      en = 2'b00;
      @(negedge clk) rst_n = 1'b1;
      cyc("rst_idle", 2'b00, 2'b00, 2'b00);
      en = 2'b01;
      for (int k = 0; k < 20; k++) cyc("rst_def", {1'b0, wv(k, 10, 5)}, {1'b0, tk(k, 10)}, 2'b00);
      wr(4'd1, 8'd3, 8'd1);
      cyc("ch1_dis_wr", {1'b0, wv(0, 10, 5)}, {1'b0, tk(0, 10)}, 2'b00);
      en = 2'b11;
      for (int j = 0; j < 15; j++)
         cyc("indep", {wv(j, 3, 1), wv(j + 1, 10, 5)}, {tk(j, 3), tk(j + 1, 10)}, 2'b00);
`ifdef CLKDIV_SYNC_EN
      en = 2'b01;
      wr(4'd1, 8'd5, 8'd2);
      cyc("sync_pre", {1'b0, wv(16, 10, 5)}, {1'b0, tk(16, 10)}, 2'b00);
      en = 2'b11;
      for (int j = 0; j < 3; j++)
         cyc("sync_pre", {wv(j, 5, 2), wv(j + 17, 10, 5)}, {tk(j, 5), tk(j + 17, 10)}, 2'b00);
      sync = 1'b1;
      cyc("sync", 2'b11, 2'b00, 2'b00);
      for (int j = 1; j < 13; j++)
         cyc("sync_post", {wv(j - 1, 5, 2), wv(j - 1, 10, 5)}, {tk(j - 1, 5), tk(j - 1, 10)}, 2'b00);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/clk_divider_multi.md
# clk_divider_multi

Parametrised multi-channel clock divider / blink generator: each of `NCH` channels divides `clk` by a runtime-programmable period and produces a duty-cycle-controlled square wave plus a one-cycle terminal tick. Period and high-time are written through a single shared config port into per-channel shadow registers and take effect glitch-free at the next period boundary. The block drives board LEDs and provides slow strobes (e.g. 1 Hz, 2 Hz) to downstream logic from the 100 MHz board clock.

## Interface
- `NCH`, 4: number of independent channels (1..16).
- `CNT_W`, 32: counter, period and high-time width.
- `DEF_PERIOD`, 100000000: reset value of every channel's active period (1 Hz at 100 MHz).
- `DEF_HIGH`, 50000000: reset value of every channel's active high-time (50 % duty).

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  NCH  per-channel run enable, synchronous.
- `cfg_we`  in  1  config write strobe, one cycle per write.
- `cfg_ch`  in  4  target channel of write.
- `cfg_period`  in  CNT_W  new period P, in clk cycles.
- `cfg_high`  in  CNT_W  new high-time H, in clk cycles.
- `sync`  in  1  global restart (present only with `CLKDIV_SYNC_EN`).
- `wave`  out  NCH  per-channel divided square wave, registered.
- `tick`  out  NCH  per-channel one-cycle pulse at end of each period, registered.
- `pend`  out  NCH  shadow config waiting to be applied.

## Operation
- Per channel state: `cnt`, active `P`/`H`, shadow `P`/`H`, `pend`.
- Reset (rst low, async): `cnt`=0, active P=`DEF_PERIOD`, H=`DEF_HIGH`, shadows = same, `wave`=0, `tick`=0, `pend`=0.
- Enabled channel, each edge: `wave` <= (`cnt` < H); `tick` <= (`cnt` == P-1); `cnt` <= (`cnt` == P-1) ? 0 : `cnt`+1. Counter counts 0..P-1, so one period is exactly P cycles.
- Duty extremes: H=0 -> `wave` constant 0; H>=P -> `wave` constant 1.
- Period clamp: written P<2 is stored as 2. H stored unmodified.
- Config write: `cfg_we` high with `cfg_ch` < `NCH` loads that channel's shadow and sets `pend`. `cfg_ch` >= `NCH` -> write ignored, no state change. A second write before apply overwrites the shadow (last write wins).
- Apply: shadow -> active, `pend` cleared, on the wrap edge (`cnt`==P-1, enabled) or on any edge while the channel is disabled. Write and wrap on the same edge: the newly written values are applied at that wrap, `pend` ends 0.
- Disabled channel (`en` bit 0): `cnt`<=0, `wave`<=0, `tick`<=0; config writes still accepted.
- Channels are fully independent; simultaneous ticks on several channels allowed.

## Timing
- First edge with `en` sampled high: `wave` rises after that edge (if H>0). `tick` is high for exactly the one cycle following edge E0+P-1, where E0 is that first edge; then every P cycles.
- `wave` and `tick` are one-cycle lagged functions of `cnt`; no combinational path from inputs to outputs.
- `pend` rises the cycle after the `cfg_we` edge; falls after the apply edge.
- Reset mid-period: outputs drop asynchronously; active config returns to defaults; shadows discarded.
- `en` deasserted mid-period: partial period abandoned, no `tick` emitted.

## Configuration
- `CLKDIV_SYNC_EN` defined: `sync` port exists. `sync` high on an edge forces `cnt`<=0 for every enabled channel, applies any pending shadow, `tick`<=0, `wave`<=(H>0). Overrides wrap and write-apply ordering that edge; a `cfg_we` on the same edge lands in shadow and is applied too. Aligns phases of all channels.
- Not defined: `sync` port absent; channels free-run from their own enable edges only.

## Test plan
- NCH=2, CNT_W=8, DEF_PERIOD=10, DEF_HIGH=5; release reset, `en`=2'b01 -> `wave[0]` 5 high / 5 low repeating, `tick[0]` every 10 cycles, channel 1 all zero.
- Write ch0 P=4,H=1 at `cnt`=3 -> `pend[0]`=1 until the wrap at `cnt`=9, then period 4, `wave` 1 high / 3 low, `pend[0]`=0.
- Write P=0 -> stored as 2, `tick` every 2 cycles; H=0 -> `wave` stuck 0; H=200 with P=10 -> `wave` stuck 1.
- Write `cfg_ch`=3 with NCH=2 -> no `pend` change, outputs unchanged; write coinciding with wrap edge -> new period starts immediately, `pend` stays 0.
- Assert `rst` low mid-period after custom config -> outputs 0 immediately; after release and enable, period back to 10.
- With `CLKDIV_SYNC_EN`, ch0 P=10, ch1 P=5 at arbitrary phases; pulse `sync` -> both `cnt`=0 next cycle, ch1 `tick` at 5 and 10 cycles later coincides with ch0 `tick` at 10.
